// File: rtl/prm_edge_pkg.sv
// ---------------------------------------------------------------------------
// prm_edge_pkg
// Shared definitions for the PRM edge-mask path.
//   - state_e       : frame accumulator FSM states (2-bit encoding)
//   - NUM_EDGES_DEF : default number of roadmap edges / parallel checkers
//   - BEAT_W_DEF    : default width of the per-frame beat counter
//   - OCC_W         : width of one obstacle-occupancy code (A..O), shared
//                     with the checker bank wrapper
// ---------------------------------------------------------------------------
package prm_edge_pkg;

    localparam int NUM_EDGES_DEF = 16;
    localparam int BEAT_W_DEF    = 12;
    localparam int OCC_W         = 15;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2,
        ST_HOLD  = 2'd3
    } state_e;

endpackage : prm_edge_pkg

// File: rtl/prm_popcount.sv
// ---------------------------------------------------------------------------
// prm_popcount
// Purely combinational population count.
// Ports:
//   data_i  [W-1:0]            input vector
//   count_o [$clog2(W+1)-1:0]  number of set bits in data_i
// ---------------------------------------------------------------------------
module prm_popcount #(
    parameter int W = 16
) (
    input  logic [W-1:0]              data_i,
    output logic [$clog2(W+1)-1:0]    count_o
);

    localparam int CW = $clog2(W + 1);

    always_comb begin
        count_o = '0;
        for (int i = 0; i < W; i++) begin
            count_o = count_o + CW'(data_i[i]);
        end
    end

endmodule : prm_popcount

// File: rtl/prm_edge_mask_accum.sv
// ---------------------------------------------------------------------------
// prm_edge_mask_accum
// OR-accumulates the edge_mask vectors produced by the checker bank over one
// scene frame and hands the blocked-edge bitmap, the free-edge count and the
// beat count to the graph-search stage through a valid/ready handshake.
//
// Ports:
//   clk           system clock, rising edge
//   rst_n         synchronous active-low reset
//   in_valid      mask beat valid
//   in_ready      block can accept a beat (IDLE/ACCUM only)
//   in_sof        first beat of a frame
//   in_eof        last beat of a frame
//   in_mask       edge_mask vector for one obstacle code
//   out_valid     frame result valid
//   out_ready     downstream accepts the result
//   out_blocked   OR of all beats in the frame (1 = edge blocked)
//   out_free_cnt  number of zero bits in out_blocked
//   out_beats     beats accumulated in the frame, saturating
//   err_sticky    protocol error seen (beat without sof in IDLE, or sof
//                 restarting a frame); cleared only by reset
// ---------------------------------------------------------------------------
module prm_edge_mask_accum
    import prm_edge_pkg::*;
#(
    parameter int NUM_EDGES = NUM_EDGES_DEF,
    parameter int BEAT_W    = BEAT_W_DEF,
    parameter int CNT_W     = $clog2(NUM_EDGES + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_sof,
    input  logic                 in_eof,
    input  logic [NUM_EDGES-1:0] in_mask,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [NUM_EDGES-1:0] out_blocked,
    output logic [CNT_W-1:0]     out_free_cnt,
    output logic [BEAT_W-1:0]    out_beats,
    output logic                 err_sticky
);

    localparam int              POP_W    = $clog2(NUM_EDGES + 1);
    localparam logic [BEAT_W-1:0] BEAT_MAX = '1;
    localparam logic [BEAT_W-1:0] BEAT_ONE = BEAT_W'(1);

    state_e                state_q, state_d;
    logic [NUM_EDGES-1:0]  acc_q, acc_d;
    logic [BEAT_W-1:0]     beats_q, beats_d;
    logic                  err_q, err_d;
    logic                  out_valid_q, out_valid_d;
    logic [NUM_EDGES-1:0]  out_blocked_q, out_blocked_d;
    logic [CNT_W-1:0]      out_free_cnt_q, out_free_cnt_d;
    logic [BEAT_W-1:0]     out_beats_q, out_beats_d;

    logic                  accept;
    logic [POP_W-1:0]      acc_pop;
    logic [CNT_W-1:0]      free_cnt;
    logic [BEAT_W-1:0]     beats_inc;

    // ------------------------------------------------------------------
    // Free-edge count from the live accumulator; registered in DONE.
    // ------------------------------------------------------------------
    prm_popcount #(
        .W (NUM_EDGES)
    ) u_popcount (
        .data_i  (acc_q),
        .count_o (acc_pop)
    );

    assign free_cnt = CNT_W'(NUM_EDGES - int'(acc_pop));

    // Saturating increment: the counter parks at all-ones, no wrap.
    assign beats_inc = (beats_q == BEAT_MAX) ? beats_q : beats_q + BEAT_ONE;

    assign accept = in_valid & in_ready;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                // Only a sof beat opens a frame; sof+eof is a one-beat frame.
                if (accept && in_sof) begin
                    state_d = in_eof ? ST_DONE : ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (accept && in_eof) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        in_ready = (state_q == ST_IDLE) || (state_q == ST_ACCUM);
    end

    // ------------------------------------------------------------------
    // Datapath next-state
    // ------------------------------------------------------------------
    always_comb begin
        acc_d          = acc_q;
        beats_d        = beats_q;
        err_d          = err_q;
        out_valid_d    = out_valid_q;
        out_blocked_d  = out_blocked_q;
        out_free_cnt_d = out_free_cnt_q;
        out_beats_d    = out_beats_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (in_sof) begin
                        acc_d   = in_mask;
                        beats_d = BEAT_ONE;
                    end else begin
                        // Orphan beat outside a frame: dropped.
                        err_d = 1'b1;
                    end
                end
            end
            ST_ACCUM: begin
                if (accept) begin
                    if (in_sof) begin
                        // Restart: discard the partial frame, keep the new one.
                        acc_d   = in_mask;
                        beats_d = BEAT_ONE;
                        err_d   = 1'b1;
                    end else begin
                        acc_d   = acc_q | in_mask;
                        beats_d = beats_inc;
                    end
                end
            end
            ST_DONE: begin
                out_blocked_d  = acc_q;
                out_free_cnt_d = free_cnt;
                out_beats_d    = beats_q;
                out_valid_d    = 1'b1;
            end
            ST_HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    acc_d       = '0;
                    beats_d     = '0;
                end
            end
            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q          <= '0;
            beats_q        <= '0;
            err_q          <= 1'b0;
            out_valid_q    <= 1'b0;
            out_blocked_q  <= '0;
            out_free_cnt_q <= '0;
            out_beats_q    <= '0;
        end else begin
            acc_q          <= acc_d;
            beats_q        <= beats_d;
            err_q          <= err_d;
            out_valid_q    <= out_valid_d;
            out_blocked_q  <= out_blocked_d;
            out_free_cnt_q <= out_free_cnt_d;
            out_beats_q    <= out_beats_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_blocked  = out_blocked_q;
    assign out_free_cnt = out_free_cnt_q;
    assign out_beats    = out_beats_q;
    assign err_sticky   = err_q;

endmodule : prm_edge_mask_accum

// File: tb/tb_prm_edge_mask_accum.sv
// ---------------------------------------------------------------------------
// tb_prm_edge_mask_accum
// Two instances share one input stream: the default one (BEAT_W=12) and a
// BEAT_W=2 one whose beat counter saturates at 3. Expected frame results are
// pushed into per-instance queues; monitors pop on every output handshake.
// ---------------------------------------------------------------------------
module tb_prm_edge_mask_accum;

    typedef struct packed {
        logic [15:0] blk;
        logic [4:0]  free;
        logic [11:0] beats;
        logic [1:0]  beats2;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_sof;
    logic        in_eof;
    logic [15:0] in_mask;
    logic        out_ready;

    logic        in_ready,  in_ready2;
    logic        out_valid, out_valid2;
    logic [15:0] out_blocked, out_blocked2;
    logic [4:0]  out_free_cnt, out_free_cnt2;
    logic [11:0] out_beats;
    logic [1:0]  out_beats2;
    logic        err_sticky, err_sticky2;

    exp_t q1[$];
    exp_t q2[$];

    int n_vec = 0;
    int n_bad = 0;

    prm_edge_mask_accum #(
        .NUM_EDGES (16),
        .BEAT_W    (12)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_sof       (in_sof),
        .in_eof       (in_eof),
        .in_mask      (in_mask),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_blocked  (out_blocked),
        .out_free_cnt (out_free_cnt),
        .out_beats    (out_beats),
        .err_sticky   (err_sticky)
    );

    prm_edge_mask_accum #(
        .NUM_EDGES (16),
        .BEAT_W    (2)
    ) dut_sat (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready2),
        .in_sof       (in_sof),
        .in_eof       (in_eof),
        .in_mask      (in_mask),
        .out_valid    (out_valid2),
        .out_ready    (out_ready),
        .out_blocked  (out_blocked2),
        .out_free_cnt (out_free_cnt2),
        .out_beats    (out_beats2),
        .err_sticky   (err_sticky2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [15:0] blk, input logic [4:0] free,
                        input logic [11:0] beats, input logic [1:0] beats2);
        exp_t e;
        e.blk = blk; e.free = free; e.beats = beats; e.beats2 = beats2;
        q1.push_back(e);
        q2.push_back(e);
    endtask

    // Drive one beat (called just after a rising edge); returns 1 time unit
    // after the edge on which it was accepted.
    task automatic beat(input logic sof, input logic eof, input logic [15:0] m);
        int n;
        in_valid = 1'b1; in_sof = sof; in_eof = eof; in_mask = m;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            n_vec++; n_bad++;
            $display("FAIL beat_accept_timeout: in_ready stuck at 0, required 1");
        end
        @(posedge clk); #1;
        $display("beat sof=%0b eof=%0b mask=0x%04h", sof, eof, m);
        in_valid = 1'b0; in_sof = 1'b0; in_eof = 1'b0; in_mask = 16'h0;
    endtask

    // Monitor for the default instance
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (q1.size() == 0) begin
                    n_vec++; n_bad++;
                    $display("FAIL out_unexpected: got blocked=0x%04h, required no output", out_blocked);
                end else begin
                    e = q1.pop_front();
                    $display("result blocked=0x%04h free=%0d beats=%0d", out_blocked, out_free_cnt, out_beats);
                    chk("out_blocked",  32'(out_blocked),  32'(e.blk));
                    chk("out_free_cnt", 32'(out_free_cnt), 32'(e.free));
                    chk("out_beats",    32'(out_beats),    32'(e.beats));
                end
            end
        end
    end

    // Monitor for the BEAT_W=2 instance
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid2 && out_ready) begin
                if (q2.size() == 0) begin
                    n_vec++; n_bad++;
                    $display("FAIL sat_out_unexpected: got blocked=0x%04h, required no output", out_blocked2);
                end else begin
                    e = q2.pop_front();
                    $display("result(w2) blocked=0x%04h free=%0d beats=%0d", out_blocked2, out_free_cnt2, out_beats2);
                    chk("sat_out_blocked",  32'(out_blocked2),  32'(e.blk));
                    chk("sat_out_free_cnt", 32'(out_free_cnt2), 32'(e.free));
                    chk("sat_out_beats",    32'(out_beats2),    32'(e.beats2));
                end
            end
        end
    end

    task automatic wait_idle();
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_eof = 1'b0;
        in_mask = 16'h0; out_ready = 1'b1;

        // --- reset state ---
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready",     32'(in_ready),     32'd1);
        chk("rst_out_valid",    32'(out_valid),    32'd0);
        chk("rst_out_blocked",  32'(out_blocked),  32'd0);
        chk("rst_out_free_cnt", 32'(out_free_cnt), 32'd0);
        chk("rst_out_beats",    32'(out_beats),    32'd0);
        chk("rst_err_sticky",   32'(err_sticky),   32'd0);
        @(posedge clk); #1;

        // --- 3-beat frame, latency eof+2 ---
        push(16'h8101, 5'd13, 12'd3, 2'd3);
        beat(1'b1, 1'b0, 16'h0001);
        beat(1'b0, 1'b0, 16'h0100);
        beat(1'b0, 1'b1, 16'h8001);
        @(negedge clk);
        chk("lat_valid_t1", 32'(out_valid), 32'd0);
        chk("lat_ready_t1", 32'(in_ready),  32'd0);
        @(negedge clk);
        chk("lat_valid_t2", 32'(out_valid), 32'd1);
        wait_idle();

        // --- single-beat frame, all edges blocked ---
        push(16'hFFFF, 5'd0, 12'd1, 2'd1);
        beat(1'b1, 1'b1, 16'hFFFF);
        @(negedge clk);
        chk("one_ready_done", 32'(in_ready),  32'd0);
        @(negedge clk);
        chk("one_ready_hold", 32'(in_ready),  32'd0);
        chk("one_valid_hold", 32'(out_valid), 32'd1);
        @(negedge clk);
        chk("one_ready_idle", 32'(in_ready),  32'd1);
        chk("one_valid_idle", 32'(out_valid), 32'd0);
        wait_idle();

        // --- backpressure with a beat held at the input ---
        out_ready = 1'b0;
        push(16'h0030, 5'd14, 12'd2, 2'd2);
        push(16'h0400, 5'd15, 12'd1, 2'd1);
        beat(1'b1, 1'b0, 16'h0010);
        beat(1'b0, 1'b1, 16'h0020);
        in_valid = 1'b1; in_sof = 1'b1; in_eof = 1'b1; in_mask = 16'h0400;
        @(negedge clk);
        chk("bp_ready_done", 32'(in_ready), 32'd0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_valid",   32'(out_valid),   32'd1);
            chk("bp_ready",   32'(in_ready),    32'd0);
            chk("bp_blocked", 32'(out_blocked), 32'h0030);
            chk("bp_beats",   32'(out_beats),   32'd2);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_valid", 32'(out_valid), 32'd1);
        @(negedge clk);
        chk("bp_after_valid", 32'(out_valid), 32'd0);
        chk("bp_after_ready", 32'(in_ready),  32'd1);
        @(posedge clk); #1;
        $display("beat sof=1 eof=1 mask=0x0400 (held)");
        in_valid = 1'b0; in_sof = 1'b0; in_eof = 1'b0; in_mask = 16'h0;
        wait_idle();

        // --- protocol errors ---
        @(negedge clk);
        chk("err_before", 32'(err_sticky), 32'd0);
        @(posedge clk); #1;
        beat(1'b0, 1'b0, 16'h1234);
        @(negedge clk);
        chk("err_orphan",       32'(err_sticky), 32'd1);
        chk("err_orphan_ready", 32'(in_ready),   32'd1);
        chk("err_orphan_valid", 32'(out_valid),  32'd0);
        @(posedge clk); #1;
        push(16'h0002, 5'd15, 12'd2, 2'd2);
        beat(1'b1, 1'b0, 16'h00F0);
        beat(1'b1, 1'b0, 16'h0000);
        beat(1'b0, 1'b1, 16'h0002);
        wait_idle();
        chk("err_still_set", 32'(err_sticky), 32'd1);

        // --- reset during ACCUM ---
        beat(1'b1, 1'b0, 16'h0F0F);
        rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("mrst_in_ready",     32'(in_ready),     32'd1);
        chk("mrst_out_valid",    32'(out_valid),    32'd0);
        chk("mrst_out_blocked",  32'(out_blocked),  32'd0);
        chk("mrst_out_free_cnt", 32'(out_free_cnt), 32'd0);
        chk("mrst_out_beats",    32'(out_beats),    32'd0);
        chk("mrst_err_sticky",   32'(err_sticky),   32'd0);
        @(posedge clk); #1;
        push(16'h0001, 5'd15, 12'd1, 2'd1);
        beat(1'b1, 1'b1, 16'h0001);
        wait_idle();

        // --- 5-beat frame: saturation on the BEAT_W=2 instance ---
        push(16'h100F, 5'd11, 12'd5, 2'd3);
        beat(1'b1, 1'b0, 16'h0001);
        beat(1'b0, 1'b0, 16'h0002);
        beat(1'b0, 1'b0, 16'h0004);
        beat(1'b0, 1'b0, 16'h0008);
        beat(1'b0, 1'b1, 16'h1000);

        // --- drain ---
        for (int i = 0; i < 100 && (q1.size() > 0 || q2.size() > 0); i++) begin
            @(negedge clk);
        end
        chk("drain_q1", 32'(q1.size()), 32'd0);
        chk("drain_q2", 32'(q2.size()), 32'd0);
        repeat (3) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_prm_edge_mask_accum

// File: doc/prm_edge_mask_accum.md
Name: prm_edge_mask_accum

Overview:
- Downstream consumer of the bank of `prm_oblgc_chk*` combinational edge checkers.
- Each checker maps one 15-bit obstacle-occupancy code (A..O) to one `edge_mask` bit per roadmap edge. The bank presents one NUM_EDGES-wide mask vector per obstacle code.
- This block OR-accumulates those vectors over one scene frame (a sequence of obstacle codes).
- At the end of the frame it emits the final blocked-edge bitmap and a free-edge count to the PRM graph-search stage, using a valid/ready handshake.

Parameters:
- NUM_EDGES, 16, number of parallel checkers, i.e. the width of the mask vector.
- BEAT_W, 12, width of the per-frame beat counter.
- CNT_W, $clog2(NUM_EDGES+1), width of the free-edge count.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  mask beat valid.
- in_ready  out  1  block can accept a beat.
- in_sof  in  1  first beat of a frame.
- in_eof  in  1  last beat of a frame.
- in_mask  in  NUM_EDGES  edge_mask outputs of the checker bank for one obstacle code.
- out_valid  out  1  frame result valid.
- out_ready  in  1  downstream accepts the result.
- out_blocked  out  NUM_EDGES  OR of all in_mask beats in the frame; 1 = edge blocked.
- out_free_cnt  out  CNT_W  number of zero bits in out_blocked.
- out_beats  out  BEAT_W  beats accumulated in the frame, saturating.
- err_sticky  out  1  protocol error flag; cleared only by reset.

Behaviour:
- One clock. Reset is synchronous and active-low: all state is cleared on the rising edge of clk while rst_n=0.
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_blocked=0, out_free_cnt=0, out_beats=0, err_sticky=0, accumulator=0, beat counter=0.
- A beat is accepted when in_valid & in_ready. All actions below apply to accepted beats only.
- States:
  - IDLE: in_ready=1.
    - sof beat: acc <= in_mask, beats <= 1. Go to ACCUM, or straight to DONE if eof is also set (single-beat frame).
    - Beat without sof: dropped, err_sticky <= 1, stay in IDLE.
  - ACCUM: in_ready=1.
    - Normal beat: acc <= acc | in_mask, beats <= sat(beats+1).
    - sof beat while in ACCUM (restart): acc <= in_mask, beats <= 1, err_sticky <= 1. The old frame is discarded.
    - eof beat: after the update, go to DONE.
  - DONE: lasts exactly one cycle. in_ready=0.
    - Latch out_blocked <= acc and out_beats <= beats.
    - Compute out_free_cnt = NUM_EDGES - popcount(acc) in the same cycle (combinational popcount, registered at the output).
    - out_valid <= 1. Go to HOLD.
  - HOLD: in_ready=0. Outputs are stable while out_valid=1 and out_ready=0.
    - On out_ready: out_valid <= 0, acc <= 0, go to IDLE.
- Latency:
  - Beat carrying eof accepted at cycle t → out_valid=1 from cycle t+2.
  - Minimum gap between frames is 2 dead input cycles (DONE, plus the HOLD handoff when out_ready is already high).
- out_valid is never deasserted without out_ready. out_* change only when entering DONE.
- Beat-counter saturation: beats stays at 2^BEAT_W-1. No wrap, no error.
- in_mask bits are used as-is. X on unaccepted beats is ignored.
- Reset mid-frame or mid-HOLD: everything returns to reset values on the next clock. A pending result is lost; no partial output is produced.
- in_sof/in_eof are ignored when in_valid=0.

Decomposition:
- Shared package prm_edge_pkg:
  - state enum {IDLE, ACCUM, DONE, HOLD}, 2 bits.
  - Default NUM_EDGES constant.
  - Checker-bank width constant OCC_W=15, shared with the checker bank wrapper.
- One sub-module, prm_popcount #(W): purely combinational population count, output width $clog2(W+1).

Test Plan (NUM_EDGES=16):
- Reset then 3-beat frame: sof 0x0001, then 0x0100, then eof 0x8001 → out_blocked=0x8101, out_free_cnt=13, out_beats=3, out_valid at eof+2.
- Single beat with sof&eof, in_mask=0xFFFF → out_blocked=0xFFFF, out_free_cnt=0, out_beats=1. in_ready=0 for exactly DONE+HOLD.
- Backpressure: out_ready=0 for 10 cycles in HOLD, with in_valid=1 → outputs stable, in_ready=0, no beat consumed. Release → out_valid drops the next cycle and the held beat is accepted in IDLE.
- Protocol errors:
  - Beat without sof in IDLE → dropped, err_sticky=1.
  - sof mid-frame after 0x00F0, followed by eof beat 0x0002 → out_blocked=0x0002, out_beats=2.
- rst_n=0 for one cycle during ACCUM (acc=0x0F0F) → all outputs 0, state IDLE. The next frame's 0x0001 alone yields 0x0001.
- BEAT_W=2 instance, 5-beat frame → out_beats=3 (saturated), OR of all 5 masks correct.
